// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, owner
// encoding, the latched access record and the abort data values.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [2:0]  FETCH_CTRL = 3'b000;

  typedef struct packed {
    owner_e      owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
  } mem_access_t;

  // Fetches are always word reads.
  function automatic mem_access_t fetch_access(input logic [31:0] addr);
    mem_access_t a;
    a.owner = OWN_IF;
    a.we    = 1'b0;
    a.addr  = addr;
    a.wdata = '0;
    a.ctrl  = FETCH_CTRL;
    return a;
  endfunction

  function automatic mem_access_t data_access(input logic        we,
                                              input logic [31:0] addr,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  ctrl);
    mem_access_t a;
    a.owner = OWN_DM;
    a.we    = we;
    a.addr  = addr;
    a.wdata = wdata;
    a.ctrl  = ctrl;
    return a;
  endfunction

  // An aborted fetch returns a NOP so the pipeline keeps executing safely.
  function automatic logic [31:0] abort_data(input owner_e owner);
    return (owner == OWN_IF) ? NOP_INSTR : 32'h0;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable saturating up-counter with clear and a terminal-count flag
// (tc is high once the count has reached TERM).
module mem_arb_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int W    = 8,
  parameter int TERM = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] TERM_V = W'(TERM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (inc && (cnt != '1))  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt >= TERM_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access with a
// req/gnt/rvalid handshake, starvation guard for fetch and a response timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int IF_MAX_WAIT = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_ctrl,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        bus_err
);

  arb_state_e  state;
  mem_access_t acc;

  logic        pick_dm, pick_if;
  logic        starve_inc, starve_clr, starve_tc;
  logic        to_clr, to_inc, to_tc;
  logic        rsp_ok, abort, finish;
  logic [31:0] rd_next;
  logic [3:0]  starve_cnt;
  logic [7:0]  to_cnt;
  logic        unused_cnt;

  mem_arb_timer #(.W(4), .TERM(IF_MAX_WAIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .clr      (starve_clr),
    .load     (1'b0),
    .load_val (4'd0),
    .inc      (starve_inc),
    .cnt      (starve_cnt),
    .tc       (starve_tc)
  );

  mem_arb_timer #(.W(8), .TERM(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (to_clr),
    .load     (1'b0),
    .load_val (8'd0),
    .inc      (to_inc),
    .cnt      (to_cnt),
    .tc       (to_tc)
  );

  assign unused_cnt = ^{starve_cnt, to_cnt};

  always_comb begin
    // Data is the older instruction, so it wins unless fetch has waited too long.
    pick_dm    = dm_req && (!starve_tc || !if_req);
    pick_if    = !pick_dm && if_req;
    starve_inc = (state == ST_IDLE) && pick_dm && if_req;
    starve_clr = (state == ST_IDLE) && pick_if;
    to_clr     = (state == ST_REQ);
    to_inc     = (state == ST_WAIT);
    rsp_ok     = ((state == ST_REQ) && mem_gnt && !acc.we && mem_rvalid) ||
                 ((state == ST_WAIT) && mem_rvalid);
    abort      = (state == ST_WAIT) && !mem_rvalid && to_tc;
    finish     = ((state == ST_REQ) && mem_gnt && acc.we) || rsp_ok || abort;
    rd_next    = abort ? abort_data(acc.owner) : mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      mem_req  <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      bus_err  <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      bus_err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_dm) begin
            acc     <= data_access(dm_we, dm_addr, dm_wdata, dm_ctrl);
            mem_req <= 1'b1;
            state   <= ST_REQ;
          end else if (pick_if) begin
            acc     <= fetch_access(if_addr);
            mem_req <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT: begin
          if (finish) begin
            mem_req <= 1'b0;
            bus_err <= abort;
            state   <= ST_DONE;
            if (acc.owner == OWN_IF) begin
              if_valid <= 1'b1;
              if (rsp_ok || abort) if_rdata <= rd_next;
            end else begin
              dm_valid <= 1'b1;
              if (rsp_ok || abort) dm_rdata <= rd_next;
            end
          end else if ((state == ST_REQ) && mem_gnt) begin
            mem_req <= 1'b0;
            state   <= ST_WAIT;
          end
        end
        ST_DONE: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_we    = acc.we;
  assign mem_addr  = acc.addr;
  assign mem_wdata = acc.wdata;
  assign mem_ctrl  = acc.ctrl;

  assign stall = rst & ((if_req & ~if_valid) | (dm_req & ~dm_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on
// the falling clock edge, expectations hand-computed per scenario.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_valid;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_ctrl;
  logic        dm_valid;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_ctrl;
  logic        mem_gnt, mem_rvalid;
  logic        stall, bus_err;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.IF_MAX_WAIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ctrl(dm_ctrl), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ctrl(mem_ctrl), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stall(stall), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_ctrl = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    if_req = 1'b1;
    #1;
    checks++; if ({mem_req, mem_we, if_valid, dm_valid, bus_err, stall} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, if_valid, dm_valid, bus_err, stall}); end
    checks++; if ({if_rdata, dm_rdata, mem_addr} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {if_rdata, dm_rdata, mem_addr}); end
    if_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h100;                      // c0
    @(negedge clk);                                        // c1
    checks++; if ({mem_req, mem_we, mem_ctrl, mem_addr} !== {1'b1, 1'b0, 3'b000, 32'h100}) begin
      errors++; $display("FAIL fetch_req: got %b/%b/%b/%h want 1/0/000/00000100", mem_req, mem_we, mem_ctrl, mem_addr); end
    mem_gnt = 1'b1;
    @(negedge clk);                                        // c2
    checks++; if ({mem_req, if_valid, stall} !== 3'b001) begin
      errors++; $display("FAIL fetch_wait: got req/valid/stall=%b want 001", {mem_req, if_valid, stall}); end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);                                        // c3
    checks++; if ({if_valid, stall, if_rdata} !== {1'b1, 1'b0, 32'h0050_0093}) begin
      errors++; $display("FAIL fetch_done: got valid=%b stall=%b rdata=%h want 1 0 00500093", if_valid, stall, if_rdata); end
    if_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);                                        // c4
    checks++; if ({if_valid, if_rdata} !== {1'b0, 32'h0050_0093}) begin
      errors++; $display("FAIL fetch_hold: got valid=%b rdata=%h want 0 00500093", if_valid, if_rdata); end
  endtask

  task automatic test_store();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF; dm_ctrl = 3'b010;
    @(negedge clk);                                        // c1
    checks++; if ({mem_req, mem_we, mem_ctrl, mem_addr, mem_wdata} !== {1'b1, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL store_req: got %b/%b/%b/%h/%h want 1/1/010/00000040/deadbeef", mem_req, mem_we, mem_ctrl, mem_addr, mem_wdata); end
    mem_gnt = 1'b1;
    @(negedge clk);                                        // c2
    checks++; if ({dm_valid, mem_req, dm_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL store_done: got valid=%b req=%b rdata=%h want 1 0 0", dm_valid, mem_req, dm_rdata); end
    dm_req = 1'b0; dm_we = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);                                        // c3
    checks++; if (dm_valid !== 1'b0) begin
      errors++; $display("FAIL store_pulse: got %b want 0", dm_valid); end
  endtask

  task automatic test_zero_wait_read();
    dm_req = 1'b1; dm_addr = 32'h80; dm_ctrl = 3'b001;
    @(negedge clk);                                        // c1
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    @(negedge clk);                                        // c2
    checks++; if ({dm_valid, dm_rdata, if_rdata} !== {1'b1, 32'h1122_3344, 32'h0050_0093}) begin
      errors++; $display("FAIL zw_read: got valid=%b dm=%h if=%h want 1 11223344 00500093", dm_valid, dm_rdata, if_rdata); end
    dm_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_conflict();
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_ctrl = 3'b100;
    @(negedge clk);                                        // c1
    checks++; if ({mem_addr, mem_ctrl} !== {32'h2000, 3'b100}) begin
      errors++; $display("FAIL conflict_first: got %h/%b want 00002000/100", mem_addr, mem_ctrl); end
    mem_gnt = 1'b1;
    @(negedge clk);                                        // c2
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_0001;
    @(negedge clk);                                        // c3
    checks++; if ({dm_valid, dm_rdata, stall} !== {1'b1, 32'hAAAA_0001, 1'b1}) begin
      errors++; $display("FAIL conflict_dm: got valid=%b rdata=%h stall=%b want 1 aaaa0001 1", dm_valid, dm_rdata, stall); end
    dm_req = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);                                        // c4
    checks++; if ({stall, mem_req} !== 2'b10) begin
      errors++; $display("FAIL conflict_gap: got stall/req=%b want 10", {stall, mem_req}); end
    @(negedge clk);                                        // c5
    checks++; if ({mem_req, mem_addr, mem_ctrl} !== {1'b1, 32'h200, 3'b000}) begin
      errors++; $display("FAIL conflict_if: got %b/%h/%b want 1/00000200/000", mem_req, mem_addr, mem_ctrl); end
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0513;
    @(negedge clk);                                        // c6
    checks++; if ({if_valid, if_rdata, stall} !== {1'b1, 32'h0000_0513, 1'b0}) begin
      errors++; $display("FAIL conflict_if_done: got valid=%b rdata=%h stall=%b want 1 00000513 0", if_valid, if_rdata, stall); end
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic [5:0] order;
    int ng;
    int ndv;
    order = '0; ng = 0; ndv = 0;
    if_req = 1'b1; if_addr = 32'h300;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_ctrl = 3'b010;
    for (int t = 0; t < 60 && ndv < 5; t++) begin
      @(negedge clk);
      if (if_valid) if_req = 1'b0;
      if (dm_valid) begin ndv++; if (ndv == 5) dm_req = 1'b0; end
      mem_gnt = mem_req; mem_rvalid = mem_req; mem_rdata = 32'(ng);
      if (mem_req) begin
        if (ng < 6) order[ng] = (mem_addr == 32'h3000);
        ng++;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    checks++; if (ndv !== 5) begin
      errors++; $display("FAIL starve_budget: dm completions %0d want 5", ndv); end
    checks++; if ({ng[3:0], order} !== {4'd6, 6'b101111}) begin
      errors++; $display("FAIL starve_order: got grants=%0d order=%b want 6 101111", ng, order); end
    checks++; if ({if_rdata, dm_rdata} !== {32'd4, 32'd5}) begin
      errors++; $display("FAIL starve_data: got if=%h dm=%h want 4 5", if_rdata, dm_rdata); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    if_req = 1'b1; if_addr = 32'h400;
    @(negedge clk);                                        // c1
    mem_gnt = 1'b1;
    @(negedge clk);                                        // c2: first WAIT cycle
    mem_gnt = 1'b0;
    checks++; if (mem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_wait_req: got %b want 0", mem_req); end
    repeat (8) begin
      @(negedge clk);                                      // c3..c10
      if (if_valid || bus_err) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin
      errors++; $display("FAIL timeout_early: got %b want 0", early); end
    @(negedge clk);                                        // c11
    checks++; if ({if_valid, bus_err, if_rdata, stall} !== {1'b1, 1'b1, 32'h13, 1'b0}) begin
      errors++; $display("FAIL timeout_done: got valid=%b err=%b rdata=%h stall=%b want 1 1 00000013 0", if_valid, bus_err, if_rdata, stall); end
    if_req = 1'b0;
    @(negedge clk);                                        // c12
    checks++; if ({if_valid, bus_err} !== 2'b00) begin
      errors++; $display("FAIL timeout_pulse: got %b want 00", {if_valid, bus_err}); end
  endtask

  task automatic test_reset_mid_access();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500; dm_ctrl = 3'b010;
    @(negedge clk);                                        // c1
    mem_gnt = 1'b1;
    @(negedge clk);                                        // c2: WAIT
    mem_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({mem_req, dm_valid, stall, mem_addr, if_rdata, dm_rdata} !== 99'h0) begin
      errors++; $display("FAIL rst_mid: got req=%b valid=%b stall=%b addr=%h if=%h dm=%h want all 0", mem_req, dm_valid, stall, mem_addr, if_rdata, dm_rdata); end
    @(negedge clk); rst = 1'b1; dm_req = 1'b0;
    @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    @(negedge clk); mem_rvalid = 1'b0;
    checks++; if ({dm_valid, mem_req, dm_rdata} !== 34'h0) begin
      errors++; $display("FAIL rst_stray_rvalid: got valid=%b req=%b rdata=%h want 0 0 0", dm_valid, mem_req, dm_rdata); end
    dm_req = 1'b1; dm_addr = 32'h600;                      // c0
    @(negedge clk);                                        // c1
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h600}) begin
      errors++; $display("FAIL rst_new_req: got %b/%h want 1/00000600", mem_req, mem_addr); end
    mem_gnt = 1'b1;
    @(negedge clk);                                        // c2
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_600D;
    @(negedge clk);                                        // c3
    checks++; if ({dm_valid, dm_rdata} !== {1'b1, 32'h0000_600D}) begin
      errors++; $display("FAIL rst_new_done: got valid=%b rdata=%h want 1 0000600d", dm_valid, dm_rdata); end
    dm_req = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_zero_wait_read();
    test_conflict();
    test_starvation();
    test_timeout();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
